// File: rtl/da_fir_serial.sv
// da_fir_serial: bit-serial distributed-arithmetic FIR with run-time loadable coefficients
module da_fir_serial #(
  parameter int N = 3,
  parameter int W = 8,
  parameter int C = 4,
  localparam int L = N > 1 ? $clog2(N) : 0,
  localparam int YW = W + C + L,
  localparam int AW = N > 1 ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [W-1:0]  x_in,
  input  logic                 coef_we,
  input  logic [AW-1:0]        coef_addr,
  input  logic [C-1:0]         coef_data,
  output logic                 out_valid,
  output logic signed [YW-1:0] y_out
);
  localparam int TW = C + L;
  localparam int CW = W > 1 ? $clog2(W) : 1;
  typedef enum logic {IDLE, RUN} st_t;
  st_t                 st_q, st_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic signed [YW-1:0] acc_q, acc_d, y_q, y_d;
  logic signed [W-1:0] x_q [N];
  logic signed [W-1:0] x_d [N];
  logic [C-1:0]        c_q [N];
  logic [C-1:0]        c_d [N];
  logic                ov_q, ov_d;
  logic [TW-1:0]       tbl [2**N];
  logic [N-1:0]        addr;
  logic [YW-1:0]       sh;
  logic                last;
  assign in_ready  = st_q == IDLE;
  assign out_valid = ov_q;
  assign y_out     = y_q;
  // DA partial-sum table rebuilt from the coefficient registers, plus the current bit-slice term
  always_comb begin
    for (int a = 0; a < 2**N; a++) begin
      tbl[a] = '0;
      for (int k = 0; k < N; k++) tbl[a] = tbl[a] + (a[k] ? TW'(c_q[k]) : TW'(0));
    end
    for (int k = 0; k < N; k++) addr[k] = x_q[k][cnt_q];
    sh   = YW'(tbl[addr]) << cnt_q;
    last = cnt_q == CW'(W - 1);
  end
  // Next-state: accept/shift and coefficient writes in IDLE, one bit-slice per edge in RUN
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    x_d   = x_q;
    c_d   = c_q;
    y_d   = y_q;
    ov_d  = 1'b0;
    if (st_q == IDLE) begin
      for (int k = 0; k < N; k++) if (coef_we && coef_addr == AW'(k)) c_d[k] = coef_data;
      if (in_valid) begin
        for (int k = 1; k < N; k++) x_d[k] = x_q[k-1];
        x_d[0] = x_in;
        acc_d  = '0;
        cnt_d  = '0;
        st_d   = RUN;
      end
    end else begin
      acc_d = last ? acc_q - $signed(sh) : acc_q + $signed(sh);
      cnt_d = cnt_q + CW'(1);
      if (last) begin
        y_d  = acc_d;
        ov_d = 1'b1;
        st_d = IDLE;
      end
    end
  end
  // State registers with synchronous reset taking priority
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q  <= IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      x_q   <= '{default: '0};
      c_q   <= '{default: '0};
      y_q   <= '0;
      ov_q  <= 1'b0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      x_q   <= x_d;
      c_q   <= c_d;
      y_q   <= y_d;
      ov_q  <= ov_d;
    end
  end
endmodule
